// File: rtl/dsp_seq_pkg.sv
// Shared encodings for the DSP operation sequencer: request modes, FSM states
// and the number of DSP passes each mode needs.
package dsp_seq_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned CNT_W  = 2;

  localparam logic [MODE_W-1:0] MODE_NARROW  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_HALF    = 2'd1;
  localparam logic [MODE_W-1:0] MODE_FULL    = 2'd2;
  localparam logic [MODE_W-1:0] MODE_ILLEGAL = 2'd3;

  localparam logic [2:0] PASSES_NARROW = 3'd1;
  localparam logic [2:0] PASSES_HALF   = 3'd2;
  localparam logic [2:0] PASSES_FULL   = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_e;

  // Illegal mode still spends one RUN cycle so it answers like a narrow op.
  function automatic logic [2:0] mode_passes(input logic [MODE_W-1:0] mode);
    case (mode)
      MODE_HALF: mode_passes = PASSES_HALF;
      MODE_FULL: mode_passes = PASSES_FULL;
      default:   mode_passes = PASSES_NARROW;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] pass_cnt_load(input logic [MODE_W-1:0] mode);
    pass_cnt_load = CNT_W'(mode_passes(mode) - 3'd1);
  endfunction

endpackage

// File: rtl/dsp_op_sequencer.sv
// Sequences one DSP operation per request over 1/2/4 passes and returns the result.
// Optional completed-operation counter enabled by macro DSP_SEQ_PERF_CNT_EN.
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 33,
  parameter int unsigned SHIFT_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [WIDTH-1:0]        req_a,
  input  logic [WIDTH-1:0]        req_b,
  input  logic [2*WIDTH-1:0]      req_c,
  input  logic [1:0]              req_mode,
  input  logic                    req_mac,
  input  logic                    req_shift_en,
  input  logic                    req_shift_dir,
  input  logic [SHIFT_BITS-1:0]   req_shift_amt,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_data,
  output logic                    rsp_err,
  output logic [WIDTH-1:0]        dsp_aa,
  output logic [WIDTH-1:0]        dsp_bb,
  output logic [2*WIDTH-1:0]      dsp_cc,
  output logic                    dsp_start,
  output logic                    dsp_mac,
  output logic                    dsp_shift_enable,
  output logic                    dsp_shift_dir,
  output logic [1:0]              dsp_mode,
  output logic [SHIFT_BITS-1:0]   dsp_shift_amount,
  input  logic [2*WIDTH-1:0]      dsp_out,
  output logic [31:0]             op_count
);

  localparam int unsigned DW = 2 * WIDTH;

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic                  illegal_q,   illegal_d;
  logic [WIDTH-1:0]      aa_q,        aa_d;
  logic [WIDTH-1:0]      bb_q,        bb_d;
  logic [DW-1:0]         cc_q,        cc_d;
  logic [1:0]            mode_q,      mode_d;
  logic                  mac_q,       mac_d;
  logic                  sh_en_q,     sh_en_d;
  logic                  sh_dir_q,    sh_dir_d;
  logic [SHIFT_BITS-1:0] sh_amt_q,    sh_amt_d;
  logic                  start_q,     start_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]         rsp_data_q,  rsp_data_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic                  req_illegal;

  assign req_ready   = (state_q == IDLE) && !rsp_valid_q;
  assign req_illegal = (req_mode == MODE_ILLEGAL);

  // Next-state and capture logic; operand registers hold between operations.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    aa_d        = aa_q;
    bb_d        = bb_q;
    cc_d        = cc_q;
    mode_d      = mode_q;
    mac_d       = mac_q;
    sh_en_d     = sh_en_q;
    sh_dir_d    = sh_dir_q;
    sh_amt_d    = sh_amt_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          illegal_d = req_illegal;
          aa_d      = req_illegal ? '0 : req_a;
          bb_d      = req_illegal ? '0 : req_b;
          cc_d      = req_c;
          mode_d    = req_illegal ? MODE_NARROW : req_mode;
          mac_d     = req_mac;
          sh_en_d   = req_shift_en;
          sh_dir_d  = req_shift_dir;
          sh_amt_d  = req_shift_amt;
          cnt_d     = pass_cnt_load(req_mode);
          start_d   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          rsp_data_d  = illegal_q ? '0 : dsp_out;
          rsp_err_d   = illegal_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      illegal_q   <= 1'b0;
      aa_q        <= '0;
      bb_q        <= '0;
      cc_q        <= '0;
      mode_q      <= '0;
      mac_q       <= 1'b0;
      sh_en_q     <= 1'b0;
      sh_dir_q    <= 1'b0;
      sh_amt_q    <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      aa_q        <= aa_d;
      bb_q        <= bb_d;
      cc_q        <= cc_d;
      mode_q      <= mode_d;
      mac_q       <= mac_d;
      sh_en_q     <= sh_en_d;
      sh_dir_q    <= sh_dir_d;
      sh_amt_q    <= sh_amt_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign dsp_aa           = aa_q;
  assign dsp_bb           = bb_q;
  assign dsp_cc           = cc_q;
  assign dsp_mode         = mode_q;
  assign dsp_mac          = mac_q;
  assign dsp_shift_enable = sh_en_q;
  assign dsp_shift_dir    = sh_dir_q;
  assign dsp_shift_amount = sh_amt_q;
  assign dsp_start        = start_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_err          = rsp_err_q;

`ifdef DSP_SEQ_PERF_CNT_EN
  logic [31:0] op_count_q, op_count_d;

  // Counts every completed response handshake, error responses included.
  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid_q && rsp_ready) op_count_d = op_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Randomized self-checking bench for dsp_op_sequencer with a multiply-add DSP model.
module tb_dsp_op_sequencer;

  localparam int unsigned W  = 33;
  localparam int unsigned SB = 2;
  localparam int unsigned DW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [W-1:0]  req_a, req_b;
  logic [DW-1:0] req_c;
  logic [1:0]    req_mode;
  logic          req_mac, req_shift_en, req_shift_dir;
  logic [SB-1:0] req_shift_amt;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic [W-1:0]  dsp_aa, dsp_bb;
  logic [DW-1:0] dsp_cc, dsp_out;
  logic          dsp_start, dsp_mac, dsp_shift_enable, dsp_shift_dir;
  logic [1:0]    dsp_mode;
  logic [SB-1:0] dsp_shift_amount;
  logic [31:0]   op_count;

  int unsigned n_vec   = 0;
  int unsigned n_err   = 0;
  int unsigned exp_ops = 0;

  always #5 clk = ~clk;

  // Simple DSP stand-in: a*b + c over the full result width.
  assign dsp_out = DW'(dsp_aa) * DW'(dsp_bb) + dsp_cc;

  dsp_op_sequencer #(.WIDTH(W), .SHIFT_BITS(SB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mode(req_mode),
    .req_mac(req_mac), .req_shift_en(req_shift_en), .req_shift_dir(req_shift_dir),
    .req_shift_amt(req_shift_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc),
    .dsp_start(dsp_start), .dsp_mac(dsp_mac), .dsp_shift_enable(dsp_shift_enable),
    .dsp_shift_dir(dsp_shift_dir), .dsp_mode(dsp_mode), .dsp_shift_amount(dsp_shift_amount),
    .dsp_out(dsp_out), .op_count(op_count)
  );

  function automatic logic any_output_set();
    any_output_set = |{rsp_valid, rsp_err, rsp_data, dsp_start, dsp_mac, dsp_aa, dsp_bb,
                       dsp_cc, dsp_mode, dsp_shift_enable, dsp_shift_dir, dsp_shift_amount,
                       op_count};
  endfunction

  // Drives one request and checks its full life cycle against the reference rules.
  task automatic run_op(input logic [1:0] mode, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [DW-1:0] c, input logic mac, input logic sen,
                        input logic sdir, input logic [SB-1:0] samt, input int hold);
    int            n;
    int            waited;
    logic [W-1:0]  ea, eb;
    logic [1:0]    em;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    n        = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 4 : 1;
    exp_err  = (mode == 2'd3);
    ea       = exp_err ? '0 : a;
    eb       = exp_err ? '0 : b;
    em       = exp_err ? 2'd0 : mode;
    exp_data = exp_err ? '0 : (DW'(a) * DW'(b) + c);

    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL req_ready_wait: got %b want 1", req_ready);
    end

    req_a = a; req_b = b; req_c = c; req_mode = mode; req_mac = mac;
    req_shift_en = sen; req_shift_dir = sdir; req_shift_amt = samt; req_valid = 1'b1;
    @(posedge clk); #1;

    // A new request held during RUN/RESP must not disturb the latched op
    req_a = W'({$urandom, $urandom}); req_b = W'({$urandom, $urandom});
    req_c = DW'({$urandom, $urandom, $urandom}); req_mode = 2'($urandom);
    req_mac = ~mac; req_shift_en = ~sen; req_shift_dir = ~sdir; req_shift_amt = ~samt;

    for (int k = 0; k < n; k++) begin
      n_vec++;
      if (dsp_start !== 1'(k == 0)) begin
        n_err++; $display("FAIL dsp_start run%0d mode%0d: got %b want %b", k, mode, dsp_start, k == 0);
      end
      n_vec++;
      if ({dsp_aa, dsp_bb, dsp_cc, dsp_mode} !== {ea, eb, c, em}) begin
        n_err++; $display("FAIL operands run%0d: got aa=%h bb=%h cc=%h mode=%0d want aa=%h bb=%h cc=%h mode=%0d",
                          k, dsp_aa, dsp_bb, dsp_cc, dsp_mode, ea, eb, c, em);
      end
      n_vec++;
      if ({dsp_mac, dsp_shift_enable, dsp_shift_dir, dsp_shift_amount} !== {mac, sen, sdir, samt}) begin
        n_err++; $display("FAIL controls run%0d: got %b%b%b%h want %b%b%b%h", k, dsp_mac,
                          dsp_shift_enable, dsp_shift_dir, dsp_shift_amount, mac, sen, sdir, samt);
      end
      n_vec++;
      if ({rsp_valid, req_ready} !== 2'b00) begin
        n_err++; $display("FAIL busy_flags run%0d: got valid=%b ready=%b want 0 0", k, rsp_valid, req_ready);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;

    n_vec++;
    if ({rsp_valid, rsp_err, dsp_start} !== {1'b1, exp_err, 1'b0}) begin
      n_err++; $display("FAIL resp_flags mode%0d: got valid=%b err=%b start=%b want 1 %b 0",
                        mode, rsp_valid, rsp_err, dsp_start, exp_err);
    end
    n_vec++;
    if (rsp_data !== exp_data) begin
      n_err++; $display("FAIL rsp_data mode%0d: got %h want %h", mode, rsp_data, exp_data);
    end

    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      n_vec++;
      if ({rsp_valid, req_ready, rsp_err, rsp_data} !== {1'b1, 1'b0, exp_err, exp_data}) begin
        n_err++; $display("FAIL hold%0d: got valid=%b ready=%b err=%b data=%h want 1 0 %b %h",
                          h, rsp_valid, req_ready, rsp_err, rsp_data, exp_err, exp_data);
      end
    end

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_ops++;
    n_vec++;
    if ({rsp_valid, req_ready, dsp_start, dsp_mac} !== {1'b0, 1'b1, 1'b0, mac}) begin
      n_err++; $display("FAIL after_hs: got valid=%b ready=%b start=%b mac=%b want 0 1 0 %b",
                        rsp_valid, req_ready, dsp_start, dsp_mac, mac);
    end
    n_vec++;
    if ({dsp_aa, dsp_bb, dsp_mode} !== {ea, eb, em}) begin
      n_err++; $display("FAIL idle_hold: got aa=%h bb=%h mode=%0d want %h %h %0d",
                        dsp_aa, dsp_bb, dsp_mode, ea, eb, em);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_c = '0; req_mode = '0;
    req_mac = 1'b0; req_shift_en = 1'b0; req_shift_dir = 1'b0; req_shift_amt = '0;
    #12;
    n_vec++;
    if (any_output_set() !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      n_err++; $display("FAIL reset_ready: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_narrow();
    run_op(2'd0, W'(3), W'(5), '0, 1'b0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_full();
    run_op(2'd2, W'(70000), W'(3), '0, 1'b0, 1'b1, 1'b0, SB'(2), 0);
  endtask

  task automatic test_backpressure();
    run_op(2'd1, W'(123456), W'(789), DW'(42), 1'b1, 1'b0, 1'b1, SB'(1), 3);
  endtask

  task automatic test_illegal();
    run_op(2'd3, W'(99), W'(77), DW'(5), 1'b0, 1'b1, 1'b1, SB'(3), 1);
  endtask

  task automatic test_back_to_back_mac();
    run_op(2'd0, W'(11), W'(13), DW'(1), 1'b1, 1'b0, 1'b0, '0, 0);
    run_op(2'd1, W'(17), W'(19), DW'(2), 1'b1, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    req_a = W'(1000); req_b = W'(7); req_c = DW'(9); req_mode = 2'd2;
    req_mac = 1'b1; req_shift_en = 1'b1; req_shift_dir = 1'b1; req_shift_amt = SB'(3);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (any_output_set() !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_outputs: got nonzero outputs, want all 0");
    end
    @(negedge clk) rst = 1'b0;
    exp_ops = 0;
    @(posedge clk); #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_mid_ready: got %b want 1", req_ready);
    end
    saw_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (saw_rsp !== 1'b0) begin
      n_err++; $display("FAIL reset_mid_no_rsp: got response after reset, want none");
    end
    run_op(2'd2, W'(321), W'(654), DW'(987), 1'b0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      run_op(2'($urandom), W'({$urandom, $urandom}), W'({$urandom, $urandom}),
             DW'({$urandom, $urandom, $urandom}), 1'($urandom), 1'($urandom), 1'($urandom),
             SB'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_op_count();
    logic [31:0] exp_cnt;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    exp_ops = 0;
    run_op(2'd0, W'(2), W'(3), '0, 1'b0, 1'b0, 1'b0, '0, 0);
    run_op(2'd1, W'(4), W'(5), '0, 1'b0, 1'b0, 1'b0, '0, 1);
    run_op(2'd3, W'(6), W'(7), '0, 1'b0, 1'b0, 1'b0, '0, 0);
    run_op(2'd2, W'(8), W'(9), '0, 1'b1, 1'b0, 1'b0, '0, 2);
    run_op(2'd0, W'(10), W'(11), '0, 1'b0, 1'b0, 1'b0, '0, 0);
`ifdef DSP_SEQ_PERF_CNT_EN
    exp_cnt = 32'(exp_ops);
`else
    exp_cnt = 32'd0;
`endif
    n_vec++;
    if (op_count !== exp_cnt) begin
      n_err++; $display("FAIL op_count: got %0d want %0d", op_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_full();
    test_backpressure();
    test_illegal();
    test_back_to_back_mac();
    test_reset_mid();
    test_random();
    test_op_count();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
